pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the execute stage of the RISC-V pipelined core. Supports logical/arithmetic shifts and rotates on an XLEN-bit operand. The log2(XLEN) barrel levels are split across STAGES register stages. A valid/ready handshake with global stall, a synchronous flush and a pass-through tag let the shifter sit behind the issue logic and take branch-mispredict kills.

---
 rtl/shifter_pkg.sv | 24 ++
 rtl/shift_level.sv | 31 +++
 rtl/pipelined_shifter.sv | 131 +++++++++++++
 tb/tb_pipelined_shifter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes and the
// mapping of barrel levels onto pipeline stages.
package shifter_pkg;

  typedef logic [2:0] shift_op_t;

  localparam shift_op_t SH_SRL = 3'b000;
  localparam shift_op_t SH_SLL = 3'b001;
  localparam shift_op_t SH_SRA = 3'b010;
  localparam shift_op_t SH_ROR = 3'b011;
  localparam shift_op_t SH_ROL = 3'b100;

  // Stage that computes barrel level 'level' when 'levels' levels are spread
  // over 'stages' register stages.
  function automatic int stage_of(input int level, input int stages, input int levels);
    return (level * stages) / levels;
  endfunction

  // Highest level index that still lands in 'stage'.
  function automatic int last_level_of(input int stage, input int stages, input int levels);
    return ((stage + 1) * levels + stages - 1) / stages - 1;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: shifts or rotates by a fixed 2**LEVEL
// positions when enabled, otherwise passes the data through.
module shift_level
  import shifter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LEVEL = 0
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      op,
  input  logic            enable,
  output logic [XLEN-1:0] result
);

  localparam int DIST = 1 << LEVEL;

  always_comb begin
    result = data;
    if (enable) begin
      case (op)
        SH_SRL:  result = data >> DIST;
        SH_SLL:  result = data << DIST;
        SH_SRA:  result = $unsigned($signed(data) >>> DIST);
        SH_ROR:  result = (data >> DIST) | (data << (XLEN - DIST));
        SH_ROL:  result = (data << DIST) | (data >> (XLEN - DIST));
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(XLEN) barrel levels split across STAGES
// register stages with a global-stall valid/ready handshake and flush.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [XLEN-1:0]         in_a,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]  stage_data  [STAGES];
  logic [SHW-1:0]   stage_shamt [STAGES];
  shift_op_t        stage_op    [STAGES];
  logic [TAG_W-1:0] stage_tag   [STAGES];
  logic [STAGES-1:0] stage_valid;

  logic [XLEN-1:0] stage_next [STAGES];
  logic [XLEN-1:0] level_out  [SHW];
  logic            advance;
  logic            unused_ctrl;

  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];
  assign out_tag   = stage_tag[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !flush;

  // Each level reads the previous level in its own stage, or the register
  // of the preceding stage (the raw inputs for stage 0) when it opens a stage.
  for (genvar i = 0; i < SHW; i++) begin : g_level
    localparam int S     = stage_of(i, STAGES, SHW);
    localparam bit FIRST = (i == 0) || (stage_of(i - 1, STAGES, SHW) != S);

    logic [XLEN-1:0] lvl_in;
    logic [2:0]      lvl_op;
    logic            lvl_en;

    if (S == 0) begin : g_ctrl_in
      assign lvl_op = in_op;
      assign lvl_en = in_shamt[i];
    end else begin : g_ctrl_reg
      assign lvl_op = stage_op[S-1];
      assign lvl_en = stage_shamt[S-1][i];
    end

    if (i == 0) begin : g_data_in
      assign lvl_in = in_a;
    end else if (FIRST) begin : g_data_reg
      assign lvl_in = stage_data[S-1];
    end else begin : g_data_chain
      assign lvl_in = level_out[i-1];
    end

    shift_level #(
      .XLEN  (XLEN),
      .LEVEL (i)
    ) u_level (
      .data   (lvl_in),
      .op     (lvl_op),
      .enable (lvl_en),
      .result (level_out[i])
    );
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage_next
    assign stage_next[s] = level_out[last_level_of(s, STAGES, SHW)];
  end

  // Flush wins over advance and stall; data registers only load behind a
  // valid slot so the output holds the last result while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int s = 0; s < STAGES; s++) begin
        stage_data[s]  <= '0;
        stage_shamt[s] <= '0;
        stage_op[s]    <= '0;
        stage_tag[s]   <= '0;
      end
    end else begin
      if (flush) begin
        stage_valid <= '0;
      end else if (advance) begin
        stage_valid[0] <= in_valid;
        for (int s = 1; s < STAGES; s++) begin
          stage_valid[s] <= stage_valid[s-1];
        end
      end

      if (advance && in_valid && !flush) begin
        stage_data[0]  <= stage_next[0];
        stage_shamt[0] <= in_shamt;
        stage_op[0]    <= in_op;
        stage_tag[0]   <= in_tag;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (advance && stage_valid[s-1]) begin
          stage_data[s]  <= stage_next[s];
          stage_shamt[s] <= stage_shamt[s-1];
          stage_op[s]    <= stage_op[s-1];
          stage_tag[s]   <= stage_tag[s-1];
        end
      end
    end
  end

  // Later stages consume only some shamt bits, and the last stage none.
  always_comb begin
    unused_ctrl = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      unused_ctrl = unused_ctrl ^ (^stage_shamt[s]) ^ (^stage_op[s]);
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: directed vectors on a 32-bit/2-stage
// instance plus a random sweep on 32-bit/1-stage and 64-bit/5-stage instances.
module tb_pipelined_shifter;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        sw_valid;
  logic        out_ready;
  logic        flush;
  logic [2:0]  in_op;
  logic [63:0] in_a;
  logic [5:0]  in_shamt;
  logic [4:0]  in_tag;

  logic        in_ready_m, out_valid_m;
  logic [31:0] out_data_m;
  logic [4:0]  out_tag_m;
  logic        ready1, valid1;
  logic [31:0] data1;
  logic [4:0]  tag1;
  logic        ready5, valid5;
  logic [63:0] data5;
  logic [4:0]  tag5;

  exp_t q_m[$];
  exp_t q_1[$];
  exp_t q_5[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  vec_t single_v [7];
  vec_t stream_v [8];

  pipelined_shifter #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_op(in_op), .in_a(in_a[31:0]), .in_shamt(in_shamt[4:0]), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_data(out_data_m), .out_tag(out_tag_m)
  );

  pipelined_shifter #(.XLEN(32), .STAGES(1), .TAG_W(5)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ready1),
    .in_op(in_op), .in_a(in_a[31:0]), .in_shamt(in_shamt[4:0]), .in_tag(in_tag),
    .flush(1'b0), .out_valid(valid1), .out_ready(1'b1),
    .out_data(data1), .out_tag(tag1)
  );

  pipelined_shifter #(.XLEN(64), .STAGES(5), .TAG_W(5)) dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ready5),
    .in_op(in_op), .in_a(in_a), .in_shamt(in_shamt), .in_tag(in_tag),
    .flush(1'b0), .out_valid(valid5), .out_ready(1'b1),
    .out_data(data5), .out_tag(tag5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a,
                              input logic [4:0] sh, input logic [4:0] tag,
                              input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.sh = sh; v.tag = tag; v.exp = exp;
    return v;
  endfunction

  // Direct reference: whole-width shift operators, independent of barrel levels.
  function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] a,
                                            input int sh, input int xlen);
    logic [63:0] mask, av, sext, r;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
    av   = a & mask;
    sext = av;
    if (xlen == 32 && av[31]) sext = av | ~mask;
    case (op)
      3'd0:    r = av >> sh;
      3'd1:    r = av << sh;
      3'd2:    r = $unsigned($signed(sext) >>> sh);
      3'd3:    r = (av >> sh) | (av << (xlen - sh));
      3'd4:    r = (av << sh) | (av >> (xlen - sh));
      default: r = av;
    endcase
    return r & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_output(input string who, input bit empty, input exp_t e,
                              input logic [63:0] data, input logic [4:0] tag, input int stages);
    if (empty) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s unexpected output: got data %h tag %0d, expected none", who, data, tag);
    end else begin
      check({who, " data"}, data, e.data);
      check({who, " tag"}, 64'(tag), 64'(e.tag));
      if (e.lat) check({who, " latency"}, 64'(cyc - e.cyc), 64'(stages));
    end
  endtask

  task automatic apply_stimulus(input logic v, input vec_t vec, input bit lat);
    in_valid = v;
    in_op    = vec.op;
    in_a     = {32'h0, vec.a};
    in_shamt = {1'b0, vec.sh};
    in_tag   = vec.tag;
    #1;
    if (in_valid && in_ready_m)
      q_m.push_back('{data: {32'h0, vec.exp}, tag: vec.tag, cyc: cyc, lat: lat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, mk(3'd0, 32'h0, 5'd0, 5'd0, 32'h0), 1'b0);
  endtask

  task automatic sweep_drive(input logic [2:0] op, input logic [63:0] a,
                             input logic [5:0] sh, input logic [4:0] tag);
    sw_valid = 1'b1;
    in_op = op; in_a = a; in_shamt = sh; in_tag = tag;
    #1;
    if (ready1)
      q_1.push_back('{data: ref_shift(op, {32'h0, a[31:0]}, int'(sh[4:0]), 32), tag: tag, cyc: cyc, lat: 1'b1});
    else check("s1 in_ready", 64'(ready1), 64'd1);
    if (ready5)
      q_5.push_back('{data: ref_shift(op, a, int'(sh), 64), tag: tag, cyc: cyc, lat: 1'b1});
    else check("w64 in_ready", 64'(ready5), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire a result whenever the consumer handshake completes.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   emp;
    if (rst_n) begin
      if (out_valid_m && out_ready && !flush) begin
        emp = (q_m.size() == 0);
        if (!emp) e = q_m.pop_front();
        check_output("main", emp, e, {32'h0, out_data_m}, out_tag_m, 2);
      end
      if (valid1) begin
        emp = (q_1.size() == 0);
        if (!emp) e = q_1.pop_front();
        check_output("s1", emp, e, {32'h0, data1}, tag1, 1);
      end
      if (valid5) begin
        emp = (q_5.size() == 0);
        if (!emp) e = q_5.pop_front();
        check_output("w64", emp, e, data5, tag5, 5);
      end
    end
  end

  initial begin
    single_v[0] = mk(3'd0, 32'h8000_0000, 5'd4,  5'd1, 32'h0800_0000);
    single_v[1] = mk(3'd1, 32'h0000_0001, 5'd31, 5'd2, 32'h8000_0000);
    single_v[2] = mk(3'd2, 32'h8000_0000, 5'd31, 5'd3, 32'hFFFF_FFFF);
    single_v[3] = mk(3'd3, 32'h0000_0001, 5'd1,  5'd4, 32'h8000_0000);
    single_v[4] = mk(3'd4, 32'h8000_0000, 5'd1,  5'd5, 32'h0000_0001);
    single_v[5] = mk(3'd2, 32'h9234_5678, 5'd0,  5'd6, 32'h9234_5678);
    single_v[6] = mk(3'd7, 32'hDEAD_BEEF, 5'd5,  5'd7, 32'hDEAD_BEEF);

    stream_v[0] = mk(3'd0, 32'hF000_0000, 5'd8,  5'd0, 32'h00F0_0000);
    stream_v[1] = mk(3'd1, 32'h0000_000F, 5'd4,  5'd1, 32'h0000_00F0);
    stream_v[2] = mk(3'd2, 32'hF000_0000, 5'd4,  5'd2, 32'hFF00_0000);
    stream_v[3] = mk(3'd3, 32'h0000_000F, 5'd4,  5'd3, 32'hF000_0000);
    stream_v[4] = mk(3'd4, 32'hF000_0000, 5'd8,  5'd4, 32'h0000_00F0);
    stream_v[5] = mk(3'd2, 32'h7000_0000, 5'd4,  5'd5, 32'h0700_0000);
    stream_v[6] = mk(3'd3, 32'h1234_5678, 5'd16, 5'd6, 32'h5678_1234);
    stream_v[7] = mk(3'd1, 32'h1234_5678, 5'd0,  5'd7, 32'h1234_5678);

    rst_n = 1'b0; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_op = 3'd0; in_a = 64'h0; in_shamt = 6'd0; in_tag = 5'd0;
    #2;
    check("reset out_valid", 64'(out_valid_m), 64'd0);
    check("reset out_data", 64'(out_data_m), 64'd0);
    check("reset out_tag", 64'(out_tag_m), 64'd0);
    check("reset in_ready", 64'(in_ready_m), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, single_v[i], 1'b1);
      idle(3);
    end

    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, stream_v[i], 1'b1);
    idle(4);

    // Stall with the pipe full: output must hold and input must be refused.
    apply_stimulus(1'b1, mk(3'd0, 32'hFFFF_FFFF, 5'd1, 5'd8, 32'h7FFF_FFFF), 1'b0);
    apply_stimulus(1'b1, mk(3'd1, 32'hFFFF_FFFF, 5'd1, 5'd9, 32'hFFFF_FFFE), 1'b0);
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b0;
      apply_stimulus(1'b1, mk(3'd2, 32'h8000_0000, 5'd1, 5'd10, 32'hC000_0000), 1'b0);
      check("stall out_valid", 64'(out_valid_m), 64'd1);
      check("stall out_data", 64'(out_data_m), 64'h7FFF_FFFF);
      check("stall out_tag", 64'(out_tag_m), 64'd8);
      check("stall in_ready", 64'(in_ready_m), 64'd0);
    end
    out_ready = 1'b1;
    apply_stimulus(1'b1, mk(3'd2, 32'h8000_0000, 5'd1, 5'd10, 32'hC000_0000), 1'b0);
    idle(4);

    // Flush with two ops in flight and a new op offered in the flush cycle.
    apply_stimulus(1'b1, mk(3'd3, 32'h0000_000A, 5'd1, 5'd11, 32'h0000_0005), 1'b0);
    apply_stimulus(1'b1, mk(3'd4, 32'h0000_0001, 5'd4, 5'd12, 32'h0000_0010), 1'b0);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 64'h100; in_shamt = 6'd8; in_tag = 5'd13;
    q_m.delete();
    #1;
    check("flush in_ready", 64'(in_ready_m), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("post-flush out_valid", 64'(out_valid_m), 64'd0);
    idle(1);
    check("post-flush out_valid 2", 64'(out_valid_m), 64'd0);
    apply_stimulus(1'b1, mk(3'd1, 32'h0000_0003, 5'd2, 5'd14, 32'h0000_000C), 1'b1);
    idle(3);

    // Asynchronous reset with a result sitting at the output.
    apply_stimulus(1'b1, mk(3'd0, 32'h0000_0010, 5'd4, 5'd15, 32'h0000_0001), 1'b0);
    apply_stimulus(1'b1, mk(3'd1, 32'h0000_0001, 5'd1, 5'd16, 32'h0000_0002), 1'b0);
    in_valid = 1'b0;
    check("pre-reset out_valid", 64'(out_valid_m), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid_m), 64'd0);
    check("async reset out_data", 64'(out_data_m), 64'd0);
    check("async reset out_tag", 64'(out_tag_m), 64'd0);
    q_m.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 64'(in_ready_m), 64'd1);
    @(posedge clk);
    #1;
    idle(3);

    for (int i = 0; i < 40; i++) begin
      case (i)
        0:       sweep_drive(3'd2, 64'h8000_0000_8000_0000, 6'd0, 5'(i));
        1:       sweep_drive(3'd2, 64'h8000_0000_8000_0000, 6'd63, 5'(i));
        2:       sweep_drive(3'd4, 64'h8000_0000_0000_0001, 6'd63, 5'(i));
        3:       sweep_drive(3'd3, 64'h0123_4567_89AB_CDEF, 6'd0, 5'(i));
        default: sweep_drive(3'($urandom_range(0, 7)), {$urandom, $urandom},
                             6'($urandom_range(0, 63)), 5'(i));
      endcase
    end
    sw_valid = 1'b0;
    idle(8);

    check("main queue drained", 64'(q_m.size()), 64'd0);
    check("s1 queue drained", 64'(q_1.size()), 64'd0);
    check("w64 queue drained", 64'(q_5.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
